tristate_bus_arb: RTL and testbench

//  Parametrised successor to the 2:1 tristate mux. N_CH sources share one W-bit tristate bus.
//  A round-robin arbiter grants the bus to one source at a time for up to HOLD_MAX beats.

---
 rtl/tristate_bus_arb_if.sv | 16 +
 rtl/tristate_bus_arb.sv | 99 +++++++++
 tb/tb_tristate_bus_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/tristate_bus_arb_if.sv
// Request/data/grant bundle between channel producers (master) and the bus arbiter (slave).
// The shared tristate bus itself stays a plain wire on the arbiter so it can reach a pad.
interface tristate_bus_arb_if #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int ID_W = $clog2(N_CH)
) ();
    logic [N_CH-1:0]   req;
    logic [N_CH*W-1:0] din;
    logic [N_CH-1:0]   gnt;
    logic              bus_vld;
    logic [ID_W-1:0]   gnt_id;

    modport master (output req, din, input gnt, bus_vld, gnt_id);
    modport slave  (input req, din, output gnt, bus_vld, gnt_id);
endinterface

// File: rtl/tristate_bus_arb.sv
// Round-robin owner of a shared tristate bus, one Z turnaround cycle after every grant; first beat one cycle after req.
// No backpressure: the owner's req level is its beat valid, dropping it ends the grant; HOLD_MAX beats per HOLD_MAX+1 cycles.
module tristate_bus_arb #(
    parameter int N_CH     = 4,
    parameter int W        = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tristate_bus_arb_if.slave bus,
    output wire  [W-1:0]      f
);
    localparam int ID_W  = $clog2(N_CH);
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state, state_nxt;
    logic [N_CH-1:0] gnt_nxt;
    logic [ID_W-1:0] gnt_id_nxt;
    logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [N_CH-1:0] req_rot;
    logic [ID_W:0]   win_sum;
    logic [ID_W-1:0] win_id;
    logic            win_vld;
    logic            owner_req;
    logic [W-1:0]    owner_dat;

    assign owner_req   = bus.req[bus.gnt_id];
    assign owner_dat   = bus.din[bus.gnt_id*W +: W];
    assign bus.bus_vld = (state == GRANT) && owner_req;
    // State is async-reset, so the pad releases as soon as rst_n falls.
    assign f = bus.bus_vld ? owner_dat : {W{1'bz}};

    // Rotate req so rr_ptr sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        req_rot = N_CH'({bus.req, bus.req} >> rr_ptr);
        win_vld = 1'b0;
        win_sum = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            end
        end
        win_id = (win_sum >= (ID_W + 1)'(N_CH)) ? ID_W'(win_sum - (ID_W + 1)'(N_CH))
                                                : ID_W'(win_sum);
    end

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = bus.gnt;
        gnt_id_nxt   = bus.gnt_id;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE, TURN: begin
                if (win_vld) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = N_CH'(1) << win_id;
                    gnt_id_nxt   = win_id;
                    beat_cnt_nxt = '0;
                end else begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                end
            end
            GRANT: begin
                if (!owner_req || beat_cnt == CNT_W'(HOLD_MAX - 1)) begin
                    state_nxt  = TURN;
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                    rr_ptr_nxt = (bus.gnt_id == ID_W'(N_CH - 1)) ? '0 : bus.gnt_id + ID_W'(1);
                end else begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.gnt    <= '0;
            bus.gnt_id <= '0;
            rr_ptr     <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            bus.gnt    <= gnt_nxt;
            bus.gnt_id <= gnt_id_nxt;
            rr_ptr     <= rr_ptr_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_tristate_bus_arb.sv
// Bench for tristate_bus_arb: vector table, directed corner sequences and random traffic vs. an ownership model.
module tb_tristate_bus_arb;
    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tristate_bus_arb_if #(.N_CH(N), .W(W)) bus ();
    wire [W-1:0] f;

    tristate_bus_arb #(.N_CH(N), .W(W), .HOLD_MAX(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .f     (f)
    );

    int errors = 0;
    int checks = 0;

    // Model: who owns the bus (-1 = nobody), beats already delivered, where the next scan starts.
    int m_owner = -1;
    int m_beats = 0;
    int m_ptr   = 0;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        logic         vld;
        logic [W-1:0] dat;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic [N-1:0] r, logic [N-1:0] g, logic v, logic [W-1:0] d);
        vec_t t;
        t.req = r; t.gnt = g; t.vld = v; t.dat = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] eg;
        logic         ev;
        eg = '0;
        ev = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = bus.req[m_owner];
        end
        chk("model_gnt", 32'(bus.gnt), 32'(eg));
        chk("model_gnt_id", 32'(bus.gnt_id), (m_owner >= 0) ? m_owner : 0);
        chk("model_vld", 32'(bus.bus_vld), 32'(ev));
        if (ev) chk("model_f", 32'(f), 32'(bus.din[m_owner*W +: W]));
        chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_owner = -1; m_beats = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner] || m_beats == H - 1) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_beats++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (bus.req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                    break;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_owner = -1; m_beats = 0; m_ptr = 0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int order[$];
        int vld_cnt;
        logic [N-1:0] prev_gnt;

        bus.req = '1;
        bus.din = {8'h33, 8'hA5, 8'h22, 8'h11};

        // Reset holds everything off even with all channels requesting.
        sample();
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_vld", 32'(bus.bus_vld), 32'h0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'h0);
        tick();
        rst_n = 1'b1;
        sample();
        chk("rel_idle_gnt", 32'(bus.gnt), 32'h0);
        tick();
        sample();
        chk("rel_first_gnt", 32'(bus.gnt), 32'h1);
        tick();

        // Single requester ch2, then wrap from rr_ptr=3 with sparse req, then drop to idle.
        tbl[0] = mk(4'b0100, 4'b0000, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) tbl[i] = mk(4'b0100, 4'b0100, 1'b1, 8'hA5);
        tbl[5] = mk(4'b0100, 4'b0000, 1'b0, 8'h00);
        for (int i = 6; i <= 9; i++) tbl[i] = mk(4'b0100, 4'b0100, 1'b1, 8'hA5);
        tbl[10] = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
        tbl[11] = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
        tbl[12] = mk(4'b1001, 4'b0000, 1'b0, 8'h00);
        for (int i = 13; i <= 16; i++) tbl[i] = mk(4'b1001, 4'b1000, 1'b1, 8'h33);
        tbl[17] = mk(4'b1001, 4'b0000, 1'b0, 8'h00);
        tbl[18] = mk(4'b1001, 4'b0001, 1'b1, 8'h11);
        tbl[19] = mk(4'b0000, 4'b0001, 1'b0, 8'h00);
        tbl[20] = mk(4'b0000, 4'b0000, 1'b0, 8'h00);
        tbl[21] = mk(4'b0000, 4'b0000, 1'b0, 8'h00);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            bus.req = tbl[i].req;
            sample();
            chk($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_vld", i), 32'(bus.bus_vld), 32'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_f", i), 32'(f), 32'(tbl[i].dat));
            tick();
        end

        // Early drop: ch1 delivers two beats, then ch2 follows after one turnaround.
        do_reset();
        bus.req = 4'b0110;
        sample(); tick();
        sample();
        chk("drop_b1_gnt", 32'(bus.gnt), 32'h2);
        chk("drop_b1_f", 32'(f), 32'h22);
        tick();
        sample();
        chk("drop_b2_vld", 32'(bus.bus_vld), 32'h1);
        tick();
        bus.req = 4'b0100;
        sample();
        chk("drop_nobeat_gnt", 32'(bus.gnt), 32'h2);
        chk("drop_nobeat_vld", 32'(bus.bus_vld), 32'h0);
        tick();
        sample();
        chk("drop_turn_gnt", 32'(bus.gnt), 32'h0);
        tick();
        sample();
        chk("drop_next_gnt", 32'(bus.gnt), 32'h4);
        chk("drop_next_f", 32'(f), 32'hA5);
        tick();

        // Async reset between edges during beat 2 of a ch2 grant.
        do_reset();
        bus.req = 4'b0100;
        sample(); tick();
        sample(); tick();
        sample();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'h0);
        chk("arst_vld", 32'(bus.bus_vld), 32'h0);
        chk("arst_gnt_id", 32'(bus.gnt_id), 32'h0);
        m_owner = -1; m_beats = 0; m_ptr = 0;
        tick();
        rst_n = 1'b1;
        bus.req = 4'hF;
        sample(); tick();
        sample();
        chk("arst_restart_gnt", 32'(bus.gnt), 32'h1);
        tick();

        // Sustained contention: order 0,1,2,3,0 and 4 beats per 5 cycles.
        do_reset();
        bus.req = 4'hF;
        prev_gnt = '0;
        vld_cnt = 0;
        for (int c = 0; c < 26; c++) begin
            bus.din = $urandom;
            sample();
            if (bus.gnt != 0 && prev_gnt == 0) order.push_back(int'(bus.gnt_id));
            if (bus.gnt != 0 && prev_gnt != 0) chk("rr_same_gnt", 32'(bus.gnt), 32'(prev_gnt));
            if (bus.bus_vld) vld_cnt++;
            prev_gnt = bus.gnt;
            tick();
        end
        chk("rr_grants", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("rr_order%0d", i), order[i], i % N);
        chk("rr_beats", vld_cnt, 20);

        // Random traffic with sticky requests against the ownership model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) bus.req = N'($urandom);
            bus.din = $urandom;
            sample();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
